datapath_pipe: RTL

- Parametrised, pipelined successor to the single-cycle register-file + ALU datapath.
- Issues one operation per cycle under a valid/ready handshake and reads two operands from an internal N-entry register file.
- Computes through a 2-stage pipeline, writes the result back to a destination register, and presents the result plus registered flags downstream.
- A load opcode writes external data into the register file through the same pipeline, so loads and ALU ops stay in program order.

---
 rtl/datapath_pkg.sv | 25 ++
 rtl/regfile_2r1w.sv | 41 ++++
 rtl/datapath_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared opcodes and flag bit positions for datapath_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Bit positions within the {N,Z,C,V} flag vector
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Register file, two combinational reads, one synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
import datapath_pkg::*;

module regfile_2r1w #(
    parameter int DATA_W    = 16,
    parameter int REG_DEPTH = 8,
    parameter int ADDR_W    = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [REG_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/datapath_pipe.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pipe
// Description : Two-stage register-file + ALU pipeline with valid/ready flow.
//               Optional macro DATAPATH_SAT_EN saturates ADD/SUB on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
import datapath_pkg::*;

module datapath_pipe #(
    parameter  int DATA_W    = 16,
    parameter  int REG_DEPTH = 8,
    localparam int ADDR_W    = $clog2(REG_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              LD,
    input  logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] num_R1,
    input  logic [ADDR_W-1:0] num_R2,
    input  logic [ADDR_W-1:0] W1,
    input  logic [2:0]        MS,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALU_out,
    output logic [3:0]        flags
);

    localparam int c_SH_W = $clog2(DATA_W);
    localparam int c_MSB  = DATA_W - 1;

    // Returns {flags[3:0], result[DATA_W-1:0]}
    function automatic logic [DATA_W+3:0] alu_eval(
        input logic              ld,
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] din
    );
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] res;
        logic [3:0]        f;
        logic              c;
        logic              v;
        logic [c_SH_W-1:0] sh;
        sum = '0;
        res = '0;
        f   = '0;
        c   = 1'b0;
        v   = 1'b0;
        sh  = b[c_SH_W-1:0];
        if (ld) begin
            res = din;
        end else begin
            case (op)
                OP_ADD: begin
                    sum = {1'b0, a} + {1'b0, b};
                    res = sum[c_MSB:0];
                    c   = sum[DATA_W];
                    v   = (a[c_MSB] == b[c_MSB]) && (res[c_MSB] != a[c_MSB]);
                end
                OP_SUB: begin
                    sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                    res = sum[c_MSB:0];
                    c   = sum[DATA_W];
                    v   = (a[c_MSB] != b[c_MSB]) && (res[c_MSB] != a[c_MSB]);
                end
                OP_AND:  res = a & b;
                OP_OR:   res = a | b;
                OP_XOR:  res = a ^ b;
                OP_SHL:  res = a << sh;
                OP_SHR:  res = a >> sh;
                default: res = a;
            endcase
        end
`ifdef DATAPATH_SAT_EN
        // Overflow direction follows A's sign for both ADD and SUB
        if (v) begin
            res = a[c_MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        f[FLG_N] = res[c_MSB];
        f[FLG_Z] = (res == '0);
        f[FLG_C] = c;
        f[FLG_V] = v;
        return {f, res};
    endfunction

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [DATA_W-1:0] r_s1_din;
    logic [2:0]        r_s1_op;
    logic              r_s1_ld;
    logic [ADDR_W-1:0] r_s1_dest;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_res;
    logic [3:0]        r_s2_flags;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W+3:0] w_alu;
    logic [DATA_W-1:0] w_s1_res;
    logic [3:0]        w_s1_flags;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_accept;

    assign w_alu      = alu_eval(r_s1_ld, r_s1_op, r_s1_a, r_s1_b, r_s1_din);
    assign w_s1_res   = w_alu[DATA_W-1:0];
    assign w_s1_flags = w_alu[DATA_W+3:DATA_W];

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;

    // The S1 result bypasses the register file it has not yet written
    assign w_opa = (r_s1_valid && (num_R1 == r_s1_dest)) ? w_s1_res : w_rd_a;
    assign w_opb = (r_s1_valid && (num_R2 == r_s1_dest)) ? w_s1_res : w_rd_b;

    regfile_2r1w #(
        .DATA_W    (DATA_W),
        .REG_DEPTH (REG_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .clk       (CLK),
        .rst       (RST),
        .i_we      (w_s1_adv),
        .i_waddr   (r_s1_dest),
        .i_wdata   (w_s1_res),
        .i_raddr_a (num_R1),
        .i_raddr_b (num_R2),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_din   <= '0;
            r_s1_op    <= '0;
            r_s1_ld    <= 1'b0;
            r_s1_dest  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_opa;
            r_s1_b     <= w_opb;
            r_s1_din   <= Din;
            r_s1_op    <= MS;
            r_s1_ld    <= LD;
            r_s1_dest  <= W1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_s2_res   <= w_s1_res;
                r_s2_flags <= w_s1_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign ALU_out   = r_s2_res;
    assign flags     = r_s2_flags;

endmodule : datapath_pipe
`default_nettype wire
